press_classifier: RTL and testbench
===================================

PRESS_CLASSIFIER -- requirements
Module: press_classifier

Interface
REQ-001 Parameter LONG_CYCLES, default 100_000_000, hold time (clk cycles) classifying a long press (1 s at 100 MHz).
REQ-002 Parameter GAP_CYCLES, default 30_000_000, max released gap (clk cycles) between presses of a double press (300 ms).
REQ-003 Parameter CNT_W, default 27, width of the internal timer; SHALL hold max(LONG_CYCLES, GAP_CYCLES)-1.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 debounced  input  1  debounced button level from the upstream edge_detector, 1 = pressed.
REQ-007 edge_trig  input  1  one-cycle pulse from upstream on each 0->1 of debounced.
REQ-008 short_press  output  1  one-cycle pulse: single press released before LONG_CYCLES, no second press within GAP_CYCLES.
REQ-009 long_press  output  1  one-cycle pulse: first press held LONG_CYCLES.
REQ-010 double_press  output  1  one-cycle pulse: second press within the gap.
REQ-011 busy  output  1  high whenever state != IDLE.
REQ-012 press_count  output  8  count of edge_trig pulses, wraps 255->0.

Function
REQ-013 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-014 Internal release = debounced registered one cycle (deb_q) with deb_q=1 and debounced=0; timer cnt SHALL clear on every state entry and increment by 1 each cycle otherwise.
REQ-015 States: IDLE, PRESS1, GAP, PRESS2, HOLD.
REQ-016 IDLE: edge_trig -> PRESS1; other inputs ignored.
REQ-017 PRESS1: debounced=1 and cnt==LONG_CYCLES-1 -> HOLD, long_press pulse; else debounced=0 -> GAP.
REQ-018 long_press SHALL be high in the cycle following exactly LONG_CYCLES rising edges after the edge that sampled edge_trig.
REQ-019 GAP: edge_trig -> PRESS2; else cnt==GAP_CYCLES-1 -> IDLE, short_press pulse.
REQ-020 Simultaneous edge_trig and cnt==GAP_CYCLES-1 in GAP: edge_trig wins (PRESS2, no short_press).
REQ-021 PRESS2: debounced=0 -> IDLE, double_press pulse; debounced=1 and cnt==LONG_CYCLES-1 -> HOLD, double_press pulse (exactly one double_press per sequence, never long_press).
REQ-022 HOLD: debounced=0 -> IDLE, no pulse.
REQ-023 edge_trig in PRESS1, PRESS2 or HOLD SHALL not change state but SHALL increment press_count.
REQ-024 At most one of short_press, long_press, double_press high in any cycle; each pulse exactly one cycle wide.
REQ-025 press_count SHALL increment on every cycle edge_trig=1 after reset, in every state, wrapping modulo 256.

Reset
REQ-026 reset=1 at a rising edge: state=IDLE, cnt=0, deb_q=0, short_press=long_press=double_press=busy=0, press_count=0.
REQ-027 Reset SHALL override all inputs; reset asserted mid-sequence (any state) SHALL abort it with no pulse emitted in or after the reset cycle.
REQ-028 First cycle after reset release SHALL accept edge_trig normally.

Verification (LONG_CYCLES=8, GAP_CYCLES=6, CNT_W=4)
REQ-029 Press 3 cycles, release, idle 10 cycles -> single short_press exactly 6 edges after GAP entry; press_count=1; busy low afterwards.
REQ-030 Press held 20 cycles -> long_press one cycle, 8 edges after edge_trig sampled; no other pulse; busy low one cycle after release.
REQ-031 Press 2 cycles, release 3 cycles, press 2 cycles, release -> one double_press after second release, no short_press; press_count=2.
REQ-032 Second edge_trig coincident with GAP cnt==5 -> double_press path, zero short_press.
REQ-033 Second press held 10 cycles -> double_press at 8th edge in PRESS2, no long_press, no pulse at release.
REQ-034 reset pulsed during PRESS1 and during GAP -> no pulse, all outputs 0, press_count=0; 256 presses -> press_count wraps to 0.

Source files
------------

// File: rtl/press_classifier_if.sv
// Button-side signal bundle for press_classifier: debounced level and edge pulse in,
// registered gesture pulses and status out.
interface press_classifier_if;
  logic       debounced;
  logic       edge_trig;
  logic       short_press;
  logic       long_press;
  logic       double_press;
  logic       busy;
  logic [7:0] press_count;

  modport master (
    output debounced,
    output edge_trig,
    input  short_press,
    input  long_press,
    input  double_press,
    input  busy,
    input  press_count
  );

  modport slave (
    input  debounced,
    input  edge_trig,
    output short_press,
    output long_press,
    output double_press,
    output busy,
    output press_count
  );
endinterface

// File: rtl/press_classifier.sv
// Classifies button activity into short, long and double presses using one shared
// timer that restarts on every state change. All outputs come straight from registers.
module press_classifier #(
  parameter int LONG_CYCLES = 100_000_000,
  parameter int GAP_CYCLES  = 30_000_000,
  parameter int CNT_W       = 27
) (
  input  logic               clk,
  input  logic               reset,
  press_classifier_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    GAP    = 3'd2,
    PRESS2 = 3'd3,
    HOLD   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             deb_q_reg;
  logic             release_w;
  logic             short_reg, short_next;
  logic             long_reg, long_next;
  logic             double_reg, double_next;
  logic             busy_reg;
  logic [7:0]       count_reg;

  // A release is the falling edge of the debounced level.
  assign release_w = deb_q_reg & ~bus.debounced;

  always_comb begin
    state_next  = state_reg;
    short_next  = 1'b0;
    long_next   = 1'b0;
    double_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.edge_trig) state_next = PRESS1;
      end
      PRESS1: begin
        if (bus.debounced && (cnt_reg == LONG_LAST)) begin
          state_next = HOLD;
          long_next  = 1'b1;
        end else if (release_w) begin
          state_next = GAP;
        end
      end
      GAP: begin
        // A new press on the last gap cycle still counts as the second press.
        if (bus.edge_trig) begin
          state_next = PRESS2;
        end else if (cnt_reg == GAP_LAST) begin
          state_next = IDLE;
          short_next = 1'b1;
        end
      end
      PRESS2: begin
        if (release_w) begin
          state_next  = IDLE;
          double_next = 1'b1;
        end else if (bus.debounced && (cnt_reg == LONG_LAST)) begin
          state_next  = HOLD;
          double_next = 1'b1;
        end
      end
      HOLD: begin
        if (release_w) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign cnt_next = (state_next != state_reg) ? '0 : cnt_reg + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      deb_q_reg  <= 1'b0;
      short_reg  <= 1'b0;
      long_reg   <= 1'b0;
      double_reg <= 1'b0;
      busy_reg   <= 1'b0;
      count_reg  <= 8'd0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      deb_q_reg  <= bus.debounced;
      short_reg  <= short_next;
      long_reg   <= long_next;
      double_reg <= double_next;
      busy_reg   <= (state_next != IDLE);
      if (bus.edge_trig) count_reg <= count_reg + 8'd1;
    end
  end

  assign bus.short_press  = short_reg;
  assign bus.long_press   = long_reg;
  assign bus.double_press = double_reg;
  assign bus.busy         = busy_reg;
  assign bus.press_count  = count_reg;

endmodule

// File: tb/tb_press_classifier.sv
// Directed scoreboard bench for press_classifier: stimulus queues expected pulses with
// their edge number, a negedge monitor pops and compares each pulse the DUT emits.
module tb_press_classifier;
  localparam int L = 8;
  localparam int G = 6;
  localparam int W = 4;

  localparam int K_SHORT  = 0;
  localparam int K_LONG   = 1;
  localparam int K_DOUBLE = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  press_classifier_if bus ();

  press_classifier #(
    .LONG_CYCLES(L),
    .GAP_CYCLES (G),
    .CNT_W      (W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int kind;
    int at;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    int   n;
    int   kind;
    exp_t e;
    while (sb.size() > 0 && sb[0].at < cyc) begin
      e = sb.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing_pulse: got no pulse at edge %0d, want kind %0d", e.at, e.kind);
    end
    n = int'(bus.short_press) + int'(bus.long_press) + int'(bus.double_press);
    if (n > 0) begin
      kind = bus.short_press ? K_SHORT : (bus.long_press ? K_LONG : K_DOUBLE);
      vectors++;
      if (n > 1) begin
        miscompares++;
        $display("FAIL pulse_overlap: got %0d pulses at edge %0d, want 1", n, cyc);
      end else if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse: got kind %0d at edge %0d, want none", kind, cyc);
      end else begin
        e = sb.pop_front();
        if (e.kind != kind || e.at != cyc) begin
          miscompares++;
          $display("FAIL pulse: got kind %0d at edge %0d, want kind %0d at edge %0d",
                   kind, cyc, e.kind, e.at);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic expect_pulse(input int kind, input int at);
    exp_t e;
    e.kind = kind;
    e.at   = at;
    sb.push_back(e);
  endtask

  // Press with edge_trig on the first cycle, keep debounced high for hold edges, then release.
  task automatic press(input int hold);
    bus.debounced = 1'b1;
    bus.edge_trig = 1'b1;
    tick();
    bus.edge_trig = 1'b0;
    repeat (hold - 1) tick();
    bus.debounced = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_short"},  int'(bus.short_press),  0);
    check({tag, "_long"},   int'(bus.long_press),   0);
    check({tag, "_double"}, int'(bus.double_press), 0);
    check({tag, "_busy"},   int'(bus.busy),         0);
    check({tag, "_count"},  int'(bus.press_count),  0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    bus.debounced = 1'b0;
    bus.edge_trig = 1'b0;
    tick();
    check_cleared(tag);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by time %0t, want finish", $time);
    $fatal(1);
  end

  initial begin
    int n;
    int m;
    reset = 1'b1;
    bus.debounced = 1'b0;
    bus.edge_trig = 1'b0;
    tick();
    do_reset("rst0");

    // Short press: release enters GAP, short pulse 6 edges later.
    n = cyc;
    expect_pulse(K_SHORT, n + 3 + 7);
    press(3);
    check("short_busy_during", int'(bus.busy), 1);
    idle(10);
    check("short_busy_after", int'(bus.busy), 0);
    check("short_count", int'(bus.press_count), 1);
    $display("txn short_press done at edge %0d", cyc);

    // Long press held 20 cycles.
    do_reset("rst1");
    n = cyc;
    expect_pulse(K_LONG, n + 9);
    press(20);
    check("long_busy_hold", int'(bus.busy), 1);
    tick();
    check("long_busy_release", int'(bus.busy), 0);
    idle(5);
    check("long_count", int'(bus.press_count), 1);
    $display("txn long_press done at edge %0d", cyc);

    // Double press with a 3-cycle gap.
    do_reset("rst2");
    press(2);
    idle(3);
    m = cyc;
    expect_pulse(K_DOUBLE, m + 3);
    press(2);
    idle(10);
    check("double_count", int'(bus.press_count), 2);
    check("double_busy", int'(bus.busy), 0);
    $display("txn double_press done at edge %0d", cyc);

    // Second press lands on the last gap cycle: still a double.
    do_reset("rst3");
    press(2);
    idle(6);
    m = cyc;
    expect_pulse(K_DOUBLE, m + 3);
    press(2);
    idle(10);
    check("edge_gap_count", int'(bus.press_count), 2);
    $display("txn gap_boundary_double done at edge %0d", cyc);

    // One cycle later the gap has expired: short, then a fresh sequence.
    do_reset("rst4");
    n = cyc;
    expect_pulse(K_SHORT, n + 9);
    press(2);
    idle(7);
    m = cyc;
    expect_pulse(K_SHORT, m + 9);
    press(2);
    idle(12);
    check("late_gap_count", int'(bus.press_count), 2);
    $display("txn gap_expired_two_shorts done at edge %0d", cyc);

    // Second press held: double at the 8th edge in PRESS2, nothing at release.
    do_reset("rst5");
    press(2);
    idle(3);
    m = cyc;
    expect_pulse(K_DOUBLE, m + 9);
    press(10);
    check("dhold_busy_hold", int'(bus.busy), 1);
    idle(10);
    check("dhold_busy_after", int'(bus.busy), 0);
    check("dhold_count", int'(bus.press_count), 2);
    $display("txn double_hold done at edge %0d", cyc);

    // Reset during PRESS1 aborts silently.
    do_reset("rst6");
    bus.debounced = 1'b1;
    bus.edge_trig = 1'b1;
    tick();
    bus.edge_trig = 1'b0;
    idle(2);
    check("p1abort_busy_before", int'(bus.busy), 1);
    reset = 1'b1;
    tick();
    check_cleared("p1abort");
    reset = 1'b0;
    idle(3);
    bus.debounced = 1'b0;
    idle(20);
    check("p1abort_count_after", int'(bus.press_count), 0);
    check("p1abort_busy_after", int'(bus.busy), 0);
    $display("txn reset_in_press1 done at edge %0d", cyc);

    // Reset during GAP, then press on the first cycle after release.
    do_reset("rst7");
    press(2);
    idle(3);
    check("gapabort_busy_before", int'(bus.busy), 1);
    reset = 1'b1;
    tick();
    check_cleared("gapabort");
    reset = 1'b0;
    n = cyc;
    expect_pulse(K_SHORT, n + 9);
    press(2);
    idle(12);
    check("gapabort_count_after", int'(bus.press_count), 1);
    $display("txn reset_in_gap done at edge %0d", cyc);

    // 256 edge_trig cycles while held: counter wraps, state only goes long once.
    do_reset("rst8");
    n = cyc;
    expect_pulse(K_LONG, n + 9);
    bus.debounced = 1'b1;
    bus.edge_trig = 1'b1;
    repeat (255) tick();
    check("wrap_count_255", int'(bus.press_count), 255);
    tick();
    check("wrap_count_0", int'(bus.press_count), 0);
    bus.edge_trig = 1'b0;
    check("wrap_busy_hold", int'(bus.busy), 1);
    bus.debounced = 1'b0;
    tick();
    check("wrap_busy_after", int'(bus.busy), 0);
    idle(5);
    $display("txn count_wrap done at edge %0d", cyc);

    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL leftover_pulse: got no pulse, want kind %0d at edge %0d", e.kind, e.at);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
